// File: rtl/dac_spi_pkg.sv
// Shared types and constants for the DAC SPI transmitter.
package dac_spi_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam int FRAME_BITS = 16;
    localparam logic [3:0] DAC_CMD_DEFAULT = 4'b0011;

    // The command nibble sits on top, with four don't-care zeros below the code.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [3:0] cmd,
                                                          input logic [7:0] code);
        return {cmd, code, 4'b0000};
    endfunction

endpackage

// File: rtl/dac_spi_tx_halfper_tick.sv
// One-cycle tick every CLK_DIV enabled cycles, marking the end of an SCLK half-period.
module spi_halfper_tick #(
    parameter int CLK_DIV = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = enable && (cnt_q == CNT_W'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dac_spi_tx.sv
// SPI mode-0 master writing one 16-bit command frame to the DAC per rising edge of spi_start.
// Optional macro SKIP_REPEAT_EN suppresses frames that would resend the last completed code.
module dac_spi_tx
    import dac_spi_pkg::*;
#(
    parameter int         CLK_DIV      = 5,
    parameter int         CS_SETUP_CYC = 2,
    parameter int         CS_HOLD_CYC  = 2,
    parameter int         CS_GAP_CYC   = 4,
    parameter logic [3:0] DAC_CMD      = DAC_CMD_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_start,
    input  logic [7:0] voltage,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n,
    output logic       busy,
    output logic       done
);

    localparam int CNT_MAX = (CS_SETUP_CYC > CS_HOLD_CYC)
                           ? ((CS_SETUP_CYC > CS_GAP_CYC) ? CS_SETUP_CYC : CS_GAP_CYC)
                           : ((CS_HOLD_CYC > CS_GAP_CYC) ? CS_HOLD_CYC : CS_GAP_CYC);
    localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [3:0]            bit_q, bit_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  cs_n_q, cs_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  start_q, start_d;

    logic                  start_edge;
    logic                  launch;
    logic                  tick;
    logic                  tick_clear;
    logic [FRAME_BITS-1:0] frame_new;

`ifdef SKIP_REPEAT_EN
    logic [7:0] last_code_q, last_code_d;
    logic [7:0] pend_code_q, pend_code_d;
    logic       code_valid_q, code_valid_d;
`endif

    assign start_edge = spi_start & ~start_q;
    assign frame_new  = build_frame(DAC_CMD, voltage);

    spi_halfper_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clear  (tick_clear),
        .enable (state_q == SHIFT),
        .tick   (tick)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        frame_d    = frame_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        start_d    = spi_start;
        launch     = 1'b0;
        tick_clear = 1'b0;
`ifdef SKIP_REPEAT_EN
        last_code_d  = last_code_q;
        pend_code_d  = pend_code_q;
        code_valid_d = code_valid_q;
`endif

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                launch = start_edge;
`ifdef SKIP_REPEAT_EN
                // A repeat of the last delivered code only acknowledges, the DAC already holds it.
                if (start_edge && code_valid_q && (voltage == last_code_q)) begin
                    launch = 1'b0;
                    busy_d = 1'b1;
                    done_d = 1'b1;
                end
                if (launch) begin
                    pend_code_d = voltage;
                end
`endif
                if (launch) begin
                    frame_d = frame_new;
                    mosi_d  = frame_new[FRAME_BITS-1];
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = SETUP;
                end
            end

            SETUP: begin
                if (cnt_q == CNT_W'(CS_SETUP_CYC - 1)) begin
                    cnt_d      = '0;
                    tick_clear = 1'b1;
                    state_d    = SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            SHIFT: begin
                // Data moves only on the falling transition so it is stable at each rise.
                if (tick) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else if (bit_q == 4'd15) begin
                        sclk_d  = 1'b0;
                        mosi_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        sclk_d  = 1'b0;
                        bit_d   = bit_q + 1'b1;
                        frame_d = {frame_q[FRAME_BITS-2:0], 1'b0};
                        mosi_d  = frame_q[FRAME_BITS-2];
                    end
                end
            end

            HOLD: begin
                if (cnt_q == CNT_W'(CS_HOLD_CYC - 1)) begin
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = GAP;
`ifdef SKIP_REPEAT_EN
                    last_code_d  = pend_code_q;
                    code_valid_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            GAP: begin
                if (cnt_q == CNT_W'(CS_GAP_CYC - 1)) begin
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // start_q resets high so a request level held through reset is not seen as an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            frame_q <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b1;
`ifdef SKIP_REPEAT_EN
            last_code_q  <= 8'h00;
            pend_code_q  <= 8'h00;
            code_valid_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            start_q <= start_d;
`ifdef SKIP_REPEAT_EN
            last_code_q  <= last_code_d;
            pend_code_q  <= pend_code_d;
            code_valid_q <= code_valid_d;
`endif
        end
    end

    assign sclk = sclk_q;
    assign mosi = mosi_q;
    assign cs_n = cs_n_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/dac_spi_tx.md
Name: dac_spi_tx

Overview:
- SPI master that sends the sweep controller's 8-bit `voltage` code to the external DAC.
- A new frame starts on each rising edge of `spi_start`. The controller holds `spi_start` high for the whole 30 us TRANSMIT window, so this block must act on the edge only.
- Sits between the sweep/noise counter and the DAC pins; one write frame per TRANSMIT window.

Parameters:
- CLK_DIV, 5, clk cycles per SCLK half-period (50 MHz clk gives 5 MHz SCLK); legal range >=1
- CS_SETUP_CYC, 2, clk cycles from cs_n low to first SCLK rising edge; legal range >=1
- CS_HOLD_CYC, 2, clk cycles from last SCLK falling edge to cs_n high; legal range >=1
- CS_GAP_CYC, 4, minimum cs_n-high clk cycles before next frame may start; legal range >=1
- DAC_CMD, 4'b0011, command nibble placed in frame bits [15:12] (write-and-update)

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- spi_start  in  1  frame request; level signal, acted on at rising edge only
- voltage  in  8  DAC code, sampled at the start edge
- sclk  out  1  SPI clock, mode 0 (idles low)
- mosi  out  1  serial data, MSB first
- cs_n  out  1  DAC chip select, active low
- busy  out  1  high from start edge until return to IDLE
- done  out  1  one-cycle pulse in the cycle cs_n returns high

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high, port names `clk` and `reset`.
- Reset values: sclk=0, mosi=0, cs_n=1, busy=0, done=0, state=IDLE, counters=0, frame register=0.
- Edge-detect register `start_q` resets to 1. A `spi_start` level held high through reset therefore never triggers a frame.
- start_edge = spi_start & ~start_q; `start_q` updates every cycle.
- Frame format: frame[15:0] = {DAC_CMD, voltage, 4'b0000}, shifted MSB first.
- IDLE:
  - On start_edge, latch the frame and go to SETUP.
  - Registered outputs in the next cycle: cs_n=0, busy=1, mosi=frame[15].
  - An edge in any other state is ignored and is not queued.
- SETUP: hold for CS_SETUP_CYC cycles with sclk=0, then go to SHIFT.
- SHIFT: each of 16 bits is CLK_DIV cycles with sclk low, then CLK_DIV cycles with sclk high.
  - mosi changes only together with the sclk falling transition, to the next bit.
  - DAC samples on the sclk rising edge.
  - After the 16th high half, sclk=0, mosi=0, go to HOLD.
- HOLD: hold for CS_HOLD_CYC cycles, then cs_n=1, done=1 for one cycle, go to GAP.
- GAP: hold for CS_GAP_CYC cycles, then go to IDLE with busy=0.
- Timing with defaults:
  - cs_n low for CS_SETUP_CYC + 32*CLK_DIV + CS_HOLD_CYC = 164 cycles (3.28 us), well inside the 30 us window.
  - Start edge to done = 165 cycles.
- Counters: bit counter is 4 bits and terminates at 15 with no wrap-around. Half-period counter width is $clog2(CLK_DIV).
- `voltage` changing mid-frame has no effect; the latched copy is used.
- Reset mid-frame: in the next cycle cs_n=1, sclk=0, mosi=0, no done pulse. The frame is aborted.
- Simultaneous start_edge and reset: reset wins.

Optional Feature:
- Macro: SKIP_REPEAT_EN.
- Defined:
  - Block keeps `last_code` (reset value 8'h00, invalid flag set).
  - On a start edge where voltage == last_code and the flag is valid, no SPI activity occurs. busy=1 and done=1 for one cycle each, starting the cycle after the edge, then back to IDLE.
  - `last_code` updates at each completed frame.
- Undefined: every start edge produces a full frame.

Decomposition:
- Package dac_spi_pkg:
  - state enum {IDLE, SETUP, SHIFT, HOLD, GAP}
  - FRAME_BITS=16
  - DAC_CMD default
  - frame-assembly function
- One natural sub-module: spi_halfper_tick, a CLK_DIV counter emitting a one-cycle tick per SCLK half-period. Enabled only in SHIFT; cleared on reset and on SHIFT entry.

Test Plan:
- voltage=8'hA5, one start edge -> mosi sampled on 16 sclk rises = 16'h3A50; cs_n low exactly 164 cycles; done at cycle 165 after the edge.
- spi_start held high 1500 cycles (30 us) -> exactly one frame; sclk has exactly 16 rising edges.
- Second start edge 50 cycles after the first -> ignored; single frame; busy stays high until the first frame's GAP ends.
- reset asserted at bit 7 of a frame -> next cycle cs_n=1, sclk=0, mosi=0, no done; start edge after reset gives a clean 8'h00 frame, 16'h3000.
- spi_start held high across reset release -> no frame until spi_start drops and rises again.
- SKIP_REPEAT_EN defined, voltage=8'h10 sent twice -> second edge gives done one cycle later, cs_n never falls; voltage=8'h11 then sends a full frame, 16'h3110.
